// File: rtl/wb_trace_if.sv
// Commit-side and trace-sink signals of the trace capture block.
// The master modport is the capture block; the slave modport is the CPU commit plus the sink.
interface wb_trace_if #(
    parameter int CW = 16
);
    logic          wb_regwrite;
    logic [31:0]   wb_regdata;
    logic          mem_memwrite;
    logic [31:0]   mem_memdata;
    logic          trace_valid;
    logic          trace_ready;
    logic [1:0]    trace_kind;
    logic [31:0]   trace_regdata;
    logic [31:0]   trace_memdata;
    logic [CW-1:0] trace_cycle;

    modport master (
        input  wb_regwrite, wb_regdata, mem_memwrite, mem_memdata, trace_ready,
        output trace_valid, trace_kind, trace_regdata, trace_memdata, trace_cycle
    );

    modport slave (
        output wb_regwrite, wb_regdata, mem_memwrite, mem_memdata, trace_ready,
        input  trace_valid, trace_kind, trace_regdata, trace_memdata, trace_cycle
    );
endinterface

// File: rtl/wb_trace_capture.sv
// Timestamps MEM/WB commit events over a fixed cycle window and drains them through a show-ahead FIFO.
// Optional running checksum output is enabled by defining WB_TRACE_CHECKSUM_EN.
module wb_trace_capture #(
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 26,
    parameter int CW         = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    wb_trace_if.master  tr,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  drop_count
`ifdef WB_TRACE_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] win_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic [7:0]    drop_reg;

    logic [1:0]    kind_mem  [DEPTH];
    logic [31:0]   reg_mem   [DEPTH];
    logic [31:0]   mem_mem   [DEPTH];
    logic [CW-1:0] stamp_mem [DEPTH];

    logic        fifo_empty, fifo_full, start_ok, push, pop, accept, drop, last_cycle;
    logic [31:0] reg_field, mem_field;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
    assign start_ok   = start && (state_reg == S_IDLE || state_reg == S_DONE);
    assign push       = (state_reg == S_RUN) && (tr.wb_regwrite || tr.mem_memwrite);
    assign pop        = !fifo_empty && tr.trace_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign accept     = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign last_cycle = (win_reg == CW'(RUN_CYCLES - 1));
    assign reg_field  = tr.wb_regwrite  ? tr.wb_regdata  : 32'd0;
    assign mem_field  = tr.mem_memwrite ? tr.mem_memdata : 32'd0;

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last_cycle) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (fifo_empty) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start_ok) state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            win_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_reg     <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                win_reg      <= '0;
                overflow_reg <= 1'b0;
                drop_reg     <= 8'd0;
            end else begin
                if (state_reg == S_RUN && win_reg != {CW{1'b1}})
                    win_reg <= win_reg + CW'(1);
                if (drop) begin
                    overflow_reg <= 1'b1;
                    if (drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
                end
            end
            if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)    rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (accept && !pop)      count_reg <= count_reg + (AW+1)'(1);
            else if (!accept && pop) count_reg <= count_reg - (AW+1)'(1);
        end
    end

    // Entry storage carries no reset; the head is masked by trace_valid instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            kind_mem[wr_ptr_reg]  <= {tr.mem_memwrite, tr.wb_regwrite};
            reg_mem[wr_ptr_reg]   <= reg_field;
            mem_mem[wr_ptr_reg]   <= mem_field;
            stamp_mem[wr_ptr_reg] <= win_reg;
        end
    end

    assign tr.trace_valid   = !fifo_empty;
    assign tr.trace_kind    = fifo_empty ? 2'b00    : kind_mem[rd_ptr_reg];
    assign tr.trace_regdata = fifo_empty ? 32'd0    : reg_mem[rd_ptr_reg];
    assign tr.trace_memdata = fifo_empty ? 32'd0    : mem_mem[rd_ptr_reg];
    assign tr.trace_cycle   = fifo_empty ? {CW{1'b0}} : stamp_mem[rd_ptr_reg];
    assign overflow         = overflow_reg;
    assign drop_count       = drop_reg;

`ifdef WB_TRACE_CHECKSUM_EN
    logic [31:0] csum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_reg <= 32'd0;
        end else if (start_ok) begin
            csum_reg <= 32'd0;
        end else if (accept) begin
            csum_reg <= {csum_reg[30:0], csum_reg[31]} ^ reg_field
                      ^ {mem_field[15:0], mem_field[31:16]} ^ 32'(win_reg);
        end
    end

    assign checksum = csum_reg;
`endif
endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture: a queue-based model checked every cycle plus literal spot checks.
module tb_wb_trace_capture;
    localparam int DEPTH = 16;
    localparam int RUNC  = 26;
    localparam int CW    = 16;

    typedef struct {
        logic [1:0]  k;
        logic [31:0] r;
        logic [31:0] m;
        logic [15:0] c;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, overflow;
    logic [7:0] drop_count;
`ifdef WB_TRACE_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    wb_trace_if #(.CW(CW)) tr ();

    wb_trace_capture #(.DEPTH(DEPTH), .RUN_CYCLES(RUNC), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tr         (tr),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .drop_count (drop_count)
`ifdef WB_TRACE_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    ent_t        got[$];
    bit          m_run, m_drain, m_done, m_ovf;
    int          m_win, m_drops;
    logic [31:0] m_csum;
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_drain = 0; m_done = 0; m_ovf = 0;
        m_win = 0; m_drops = 0; m_csum = 32'd0;
    endtask

    // Advances the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        int   pre_len;
        bit   do_pop, do_push;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pre_len = mq.size();
        do_pop  = (pre_len > 0) && tr.trace_ready;
        do_push = 0;
        if (start && !m_run && !m_drain) begin
            m_run = 1; m_drain = 0; m_done = 0; m_win = 0;
            m_ovf = 0; m_drops = 0; m_csum = 32'd0;
        end else if (m_run) begin
            if (tr.wb_regwrite || tr.mem_memwrite) begin
                e.k = {tr.mem_memwrite, tr.wb_regwrite};
                e.r = tr.wb_regwrite  ? tr.wb_regdata  : 32'd0;
                e.m = tr.mem_memwrite ? tr.mem_memdata : 32'd0;
                e.c = 16'(m_win);
                if (pre_len < DEPTH || do_pop) begin
                    do_push = 1;
                    m_csum = {m_csum[30:0], m_csum[31]} ^ e.r ^ {e.m[15:0], e.m[31:16]} ^ 32'(e.c);
                end else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (m_win == RUNC - 1) begin
                m_run = 0;
                m_drain = 1;
            end else begin
                m_win++;
            end
        end else if (m_drain && pre_len == 0) begin
            m_drain = 0;
            m_done = 1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            ent_t h;
            h = '{2'b00, 32'd0, 32'd0, 16'd0};
            if (mq.size() > 0) h = mq[0];
            chk("trace_valid", 32'(tr.trace_valid), 32'(mq.size() > 0));
            chk("trace_kind", 32'(tr.trace_kind), 32'(h.k));
            chk("trace_regdata", tr.trace_regdata, h.r);
            chk("trace_memdata", tr.trace_memdata, h.m);
            chk("trace_cycle", 32'(tr.trace_cycle), 32'(h.c));
            chk("busy", 32'(busy), 32'(m_run | m_drain));
            chk("done", 32'(done), 32'(m_done));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_count", 32'(drop_count), 32'(m_drops));
`ifdef WB_TRACE_CHECKSUM_EN
            chk("checksum", checksum, m_csum);
`endif
        end
    end

    task automatic drive(input bit st, input bit rw, input logic [31:0] rd,
                         input bit mw, input logic [31:0] md, input bit rdy);
        ent_t e;
        @(negedge clk);
        #1;
        start = st;
        tr.wb_regwrite = rw;
        tr.wb_regdata = rd;
        tr.mem_memwrite = mw;
        tr.mem_memdata = md;
        tr.trace_ready = rdy;
        if (tr.trace_valid && rdy) begin
            e = '{tr.trace_kind, tr.trace_regdata, tr.trace_memdata, tr.trace_cycle};
            got.push_back(e);
            $display("pop kind=%b reg=%h mem=%h cycle=%0d", e.k, e.r, e.m, e.c);
        end
        model_step();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80; i++) begin
            if (done) break;
            drive(0, 0, 32'd0, 0, 32'd0, 1);
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        tr.wb_regwrite = 0; tr.wb_regdata = 0; tr.mem_memwrite = 0;
        tr.mem_memdata = 0; tr.trace_ready = 0;
        model_reset();
        drive(0, 0, 32'd0, 0, 32'd0, 0);
        chk_en = 1;
        drive(0, 0, 32'd0, 0, 32'd0, 0);
        rst_n = 1;
        drive(0, 0, 32'd0, 0, 32'd0, 0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(tr.trace_valid), 32'd0);

        // Single reg write at cycle 3, dual write at cycle 7.
        got.delete();
        drive(1, 0, 32'd0, 0, 32'd0, 1);
        for (int k = 0; k < RUNC; k++)
            drive(0, (k == 3) || (k == 7), (k == 3) ? 32'h5 : 32'hAAAA0000,
                  k == 7, 32'h12345678, 1);
        wait_done();
        chk("t1_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t1_kind0", 32'(got[0].k), 32'd1);
            chk("t1_reg0", got[0].r, 32'h5);
            chk("t1_mem0", got[0].m, 32'h0);
            chk("t1_cyc0", 32'(got[0].c), 32'd3);
            chk("t2_kind1", 32'(got[1].k), 32'd3);
            chk("t2_reg1", got[1].r, 32'hAAAA0000);
            chk("t2_mem1", got[1].m, 32'h12345678);
            chk("t2_cyc1", 32'(got[1].c), 32'd7);
        end

        // Overflow: 20 back-to-back writes into a stalled sink.
        got.delete();
        drive(1, 0, 32'd0, 0, 32'd0, 0);
        for (int k = 0; k < RUNC; k++)
            drive(0, k < 20, 32'(k), 0, 32'd0, 0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_drops", 32'(drop_count), 32'd4);
        wait_done();
        chk("t3_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size(); i++) begin
            chk("t3_cyc", 32'(got[i].c), 32'(i));
            chk("t3_reg", got[i].r, 32'(i));
        end

        // Restart from DONE clears the sticky flags.
        got.delete();
        drive(1, 0, 32'd0, 0, 32'd0, 1);
        drive(0, 0, 32'd0, 0, 32'd0, 1);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_drops", 32'(drop_count), 32'd0);
        for (int k = 1; k < RUNC; k++)
            drive(0, k == 3, 32'h5, 0, 32'd0, 1);
        wait_done();
        chk("t6_count", 32'(got.size()), 32'd1);
`ifdef WB_TRACE_CHECKSUM_EN
        chk("t6_checksum", checksum, 32'h6);
`endif

        // Full FIFO with a simultaneous pop accepts the push.
        got.delete();
        drive(1, 0, 32'd0, 0, 32'd0, 0);
        for (int k = 0; k < RUNC; k++)
            drive(0, k <= 16, 32'h100 + 32'(k), 0, 32'd0, k == 16);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_drops", 32'(drop_count), 32'd0);
        wait_done();
        chk("t4_count", 32'(got.size()), 32'd17);
        if (got.size() == 17) chk("t4_last_cyc", 32'(got[16].c), 32'd16);

        // Asynchronous reset with entries buffered.
        got.delete();
        drive(1, 0, 32'd0, 0, 32'd0, 0);
        for (int k = 0; k < 5; k++)
            drive(0, 1, 32'hC0 + 32'(k), 0, 32'd0, 0);
        drive(0, 0, 32'd0, 0, 32'd0, 0);
        #1;
        rst_n = 0;
        model_reset();
        #1;
        chk("t5_valid", 32'(tr.trace_valid), 32'd0);
        chk("t5_kind", 32'(tr.trace_kind), 32'd0);
        chk("t5_reg", tr.trace_regdata, 32'd0);
        chk("t5_mem", tr.trace_memdata, 32'd0);
        chk("t5_cyc", 32'(tr.trace_cycle), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        drive(0, 0, 32'd0, 0, 32'd0, 0);
        drive(0, 0, 32'd0, 0, 32'd0, 0);
        rst_n = 1;
        drive(1, 0, 32'd0, 0, 32'd0, 1);
        drive(0, 1, 32'h77, 0, 32'd0, 1);
        for (int k = 1; k < RUNC; k++)
            drive(0, 0, 32'd0, 0, 32'd0, 1);
        wait_done();
        chk("t5_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) begin
            chk("t5_first_cyc", 32'(got[0].c), 32'd0);
            chk("t5_first_reg", got[0].r, 32'h77);
        end

        drive(0, 0, 32'd0, 0, 32'd0, 0);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
